accumulate_sequencer: RTL

//  Time-shares one signed multiply-accumulate datapath between NUM_REQ audio-effect requesters.
//  - Round-robin grant to one requester.
//  - Streams LEN sample/coefficient pairs from a circular sample buffer, starting at the

---
 rtl/accum_seq_pkg.sv | 23 ++
 rtl/accumulate_sequencer_rr_arbiter.sv | 28 ++
 rtl/accumulate_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/accum_seq_pkg.sv
// accum_seq_pkg: shared widths, FSM encoding and Q1.15 saturation helper for accumulate_sequencer
package accum_seq_pkg;
    localparam int NUM_REQ_D = 4;
    localparam int DATA_W_D  = 16;
    localparam int ADDR_W_D  = 10;
    localparam int LEN_W_D   = 10;
    localparam int ACC_W_D   = 40;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_DRAIN1 = 3'd2;
    localparam logic [2:0] S_DRAIN2 = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    typedef struct packed {
        logic        sat;
        logic [15:0] val;
    } sat_t;
    function automatic sat_t sat_q115(input logic signed [63:0] v);
        logic signed [63:0] s;
        s = v >>> 15;
        sat_q115.sat = (s > 32767) || (s < -32768);
        sat_q115.val = (s > 32767) ? 16'h7fff : (s < -32768) ? 16'h8000 : s[15:0];
    endfunction
endpackage

// File: rtl/accumulate_sequencer_rr_arbiter.sv
// rr_arbiter: picks the first set request at or after the pointer, wrapping around
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);
    int j;
    // scan requesters starting at the pointer; first hit wins
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[IDX_W'(j)]) begin
                any                = 1'b1;
                win_idx            = IDX_W'(j);
                win[IDX_W'(j)]     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/accumulate_sequencer.sv
// accumulate_sequencer: round-robin shared signed MAC over a circular sample buffer
module accumulate_sequencer
    import accum_seq_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int ADDR_W  = ADDR_W_D,
    parameter int LEN_W   = LEN_W_D,
    parameter int ACC_W   = ACC_W_D
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         result,
    output logic                      result_valid,
    output logic                      sat,
    output logic                      mem_rd,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         samp_rdata,
    input  logic [DATA_W-1:0]         coef_rdata,
    output logic                      busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    logic [2:0]                 state;
    logic [IDX_W-1:0]           ptr, gidx, win_idx;
    logic [NUM_REQ-1:0]         win;
    logic                       any;
    logic [ADDR_W-1:0]          base, base_sel;
    logic [LEN_W-1:0]           len, len_sel, count;
    logic                       rd_d1, prod_v;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc, acc_nxt;
    sat_t                       st;
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );
    assign base_sel = req_base[win_idx*ADDR_W +: ADDR_W];
    assign len_sel  = req_len[win_idx*LEN_W +: LEN_W];
    assign busy     = state != S_IDLE;
    assign mem_rd   = state == S_RUN;
    assign mem_addr = mem_rd ? base + ADDR_W'(count) : '0;
    assign acc_nxt  = acc + (prod_v ? ACC_W'(prod) : '0);
    assign st       = sat_q115(64'(acc_nxt));
    // FSM, address counter and MAC pipe; the final product is folded in while leaving DRAIN2
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            grant        <= '0;
            done         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            sat          <= 1'b0;
            ptr          <= '0;
            gidx         <= '0;
            base         <= '0;
            len          <= '0;
            count        <= '0;
            acc          <= '0;
            rd_d1        <= 1'b0;
            prod_v       <= 1'b0;
            prod         <= '0;
        end else begin
            done         <= '0;
            result_valid <= 1'b0;
            sat          <= 1'b0;
            rd_d1        <= mem_rd;
            prod_v       <= rd_d1;
            prod         <= $signed(samp_rdata) * $signed(coef_rdata);
            acc          <= acc_nxt;
            case (state)
                S_IDLE: if (any) begin
                    grant <= win;
                    gidx  <= win_idx;
                    base  <= base_sel;
                    len   <= len_sel;
                    count <= '0;
                    acc   <= '0;
                    state <= (len_sel == '0) ? S_DRAIN2 : S_RUN;
                end
                S_RUN: begin
                    count <= count + 1'b1;
                    state <= (count == len - 1'b1) ? S_DRAIN1 : S_RUN;
                end
                S_DRAIN1: state <= S_DRAIN2;
                S_DRAIN2: begin
                    result       <= st.val;
                    sat          <= st.sat;
                    done         <= grant;
                    result_valid <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    grant <= '0;
                    ptr   <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
